mux_fault_locator: RTL and testbench
====================================

// Module: mux_fault_locator
// PURPOSE
//  Clocked self-test and fault-localisation engine for a WIDTH-bit 2:1 mux under test.
//  The mux under test exposes 9 internal wires per bit slice.
//  The block steps all 8 {I0,I1,S} vectors, replicated across every slice, and waits SETTLE cycles per vector.
//  It compares the observed wires against an internal golden model and narrows a per-slice suspect-wire mask.
//  Sits beside the mux under test on the lab board; results are read out after done.
// PARAMETERS
//  WIDTH   4   data bits of the mux under test (slices); suspect/obs width = 9*WIDTH
//  SETTLE  2   wait cycles between driving a vector and sampling obs_wires (>=1)
// PORTS
//  clk         in   1        system clock, all logic on rising edge
//  rst         in   1        synchronous, active-high reset
//  start       in   1        1-cycle pulse; begins a run from IDLE or DONE
//  mux_s       out  1        select driven to the mux under test
//  mux_i0      out  WIDTH    data-0 driven to the mux under test
//  mux_i1      out  WIDTH    data-1 driven to the mux under test
//  obs_wires   in   9*WIDTH  observed wires; slice b wire k at bit 9*b+k
//  busy        out  1        high from the cycle after start until done
//  done        out  1        high in DONE; held until next start or rst
//  pass        out  1        done && fail_count==0
//  fail_count  out  4        number of vectors with any mismatch (0..8)
//  suspect     out  9*WIDTH  per-slice suspect mask; 1 = wire may be faulty
// BEHAVIOUR
//  Reset: state=IDLE; mux_s=0, mux_i0=0, mux_i1=0; busy=0, done=0, pass=0, fail_count=0; suspect=all 1s.
//  Vector idx 0..7: I0=idx[2], I1=idx[1], S=idx[0]; I0/I1 replicated on all WIDTH bits.
//  Golden wire k per slice:
//   0:I0  1:I1  2:S  3:S  4:S  5:~S  6:I1&S  7:I0&~S  8:(I1&S)|(I0&~S).
//  DEP[k] (9-bit, bit8..bit0):
//   0:0x100  1:0x080  2:0x040  3:0x060  4:0x050  5:0x058  6:0x0E4  7:0x15A  8:0x1FF.
//  FSM states:
//   IDLE --start--> DRIVE: suspect:=all 1s, fail_count:=0, idx:=0, busy:=1.
//   DRIVE (1 cycle): drive vector idx; wait counter := SETTLE-1; -> WAIT.
//   WAIT (SETTLE cycles, inputs held): at count 0 -> CHECK.
//   CHECK (1 cycle): sample obs_wires; apply the mismatch and update rules below.
//    Then: idx==7 -> DONE, else idx+1 -> DRIVE.
//   DONE: busy=0, done=1, stimulus returns to 0. start -> re-init as from IDLE, done:=0.
//  CHECK rules, per slice b:
//   - if any wire mismatches, let k* = highest mismatching k; suspect[9b+8:9b] &= DEP[k*].
//   - slices with no mismatch are unchanged.
//   - fail_count increments once per vector if any slice mismatched; saturates at 8.
//  Latency: SETTLE+2 cycles per vector; done rises 8*(SETTLE+2)+1 cycles after start is sampled.
//  Boundary cases:
//   - start while busy is ignored.
//   - start and rst in the same cycle: rst wins.
//   - rst mid-run: next cycle is IDLE with all reset values; the partial suspect mask is discarded.
//   - obs_wires is sampled only in CHECK; glitches in DRIVE/WAIT have no effect.
// TESTING
//  1 Fault-free model, WIDTH=4, SETTLE=2, start -> done at +33 cycles, pass=1, fail_count=0, suspect=36'hFFFFFFFFF.
//  2 Slice0 wire7 forced 0 (only that bit), start -> fail_count=2 (idx 4,6), suspect[8:0]=0x15A, others 0x1FF.
//  3 Slice2 wire6 forced 1 (only that bit), start -> fail_count=6, suspect[26:18]=0x0E4, others 0x1FF, pass=0.
//  4 Slice1 wire8 forced 0 -> fail_count=4 (idx 3,4,6,7), suspect all 1s, pass=0.
//  5 rst asserted in WAIT of idx 3 -> next cycle busy=0, done=0, fail_count=0, mux_* =0, suspect all 1s.
//  6 start pulsed at idx 5 -> ignored, run ends at normal cycle; start in DONE -> fresh run, results re-initialised.

Source files
------------

// File: rtl/mux_fault_locator.sv
// mux_fault_locator
//   Self-test and fault-localisation engine for a WIDTH-bit 2:1 mux under test.
//   Steps the eight {I0,I1,S} vectors (replicated over every slice), waits
//   SETTLE cycles per vector, then compares the nine observed internal wires
//   of each slice against a golden model and narrows a per-slice suspect mask.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : 1-cycle pulse, starts a run from IDLE or DONE
//   mux_s      : select driven to the mux under test
//   mux_i0     : data-0 driven to the mux under test (WIDTH bits)
//   mux_i1     : data-1 driven to the mux under test (WIDTH bits)
//   obs_wires  : observed wires, slice b wire k at bit 9*b+k
//   busy       : run in progress
//   done       : run complete, held until next start or rst
//   pass       : done with no failing vector
//   fail_count : number of vectors with any mismatch (0..8)
//   suspect    : per-slice suspect mask, 1 = wire may be faulty
module mux_fault_locator #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               mux_s,
  output logic [WIDTH-1:0]   mux_i0,
  output logic [WIDTH-1:0]   mux_i1,
  input  logic [9*WIDTH-1:0] obs_wires,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [3:0]         fail_count,
  output logic [9*WIDTH-1:0] suspect
);

  localparam int unsigned NW = 9 * WIDTH;
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      fail_q, fail_d;
  logic [NW-1:0]   susp_q, susp_d;

  logic [NW-1:0]   susp_chk;
  logic            any_mis;
  logic [8:0]      gold;
  logic [8:0]      mism;
  logic [3:0]      kstar;
  logic            active;

  // Fault-free value of the nine internal wires of one slice.
  function automatic logic [8:0] golden(input logic i0, input logic i1, input logic s);
    golden = {(i1 & s) | (i0 & ~s), i0 & ~s, i1 & s, ~s, s, s, s, i1, i0};
  endfunction

  // Wires that can explain a mismatch whose highest mismatching wire is k.
  function automatic logic [8:0] dep(input logic [3:0] k);
    case (k)
      4'd0:    dep = 9'h100;
      4'd1:    dep = 9'h080;
      4'd2:    dep = 9'h040;
      4'd3:    dep = 9'h060;
      4'd4:    dep = 9'h050;
      4'd5:    dep = 9'h058;
      4'd6:    dep = 9'h0E4;
      4'd7:    dep = 9'h15A;
      default: dep = 9'h1FF;
    endcase
  endfunction

  // Per-slice comparison; only consumed in CHECK.
  always_comb begin : check_logic
    any_mis  = 1'b0;
    susp_chk = susp_q;
    gold     = golden(idx_q[2], idx_q[1], idx_q[0]);
    mism     = '0;
    kstar    = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      mism  = obs_wires[9*b +: 9] ^ gold;
      kstar = '0;
      for (int unsigned k = 0; k < 9; k++) begin
        if (mism[k]) kstar = 4'(k);
      end
      if (|mism) begin
        any_mis = 1'b1;
        susp_chk[9*b +: 9] = susp_q[9*b +: 9] & dep(kstar);
      end
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    susp_d  = susp_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          fail_d  = '0;
          susp_d  = '1;
        end
      end
      DRIVE: begin
        cnt_d   = CW'(SETTLE - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - CW'(1);
      end
      CHECK: begin
        susp_d = susp_chk;
        if (any_mis && fail_q != 4'd8) fail_d = fail_q + 4'd1;
        if (idx_q == 3'd7) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      susp_q  <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      susp_q  <= susp_d;
    end
  end

  assign active     = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CHECK);
  assign mux_s      = active & idx_q[0];
  assign mux_i0     = active ? {WIDTH{idx_q[2]}} : '0;
  assign mux_i1     = active ? {WIDTH{idx_q[1]}} : '0;
  assign busy       = active;
  assign done       = (state_q == DONE);
  assign pass       = done && (fail_q == 4'd0);
  assign fail_count = fail_q;
  assign suspect    = susp_q;

endmodule

// File: tb/tb_mux_fault_locator.sv
// Testbench for mux_fault_locator: emulates the mux under test with
// injectable stuck-at faults and glitch noise, and checks the engine's
// timing, stimulus and results against a vector-level reference model.
module tb_mux_fault_locator;

  localparam int unsigned W   = 4;
  localparam int unsigned S   = 2;
  localparam int unsigned NW  = 9 * W;
  localparam int unsigned VC  = S + 2;
  localparam int unsigned RUN = 8 * VC;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mux_s;
  logic [W-1:0]  mux_i0;
  logic [W-1:0]  mux_i1;
  logic [NW-1:0] obs_wires;
  logic          busy;
  logic          done;
  logic          pass;
  logic [3:0]    fail_count;
  logic [NW-1:0] suspect;

  logic [NW-1:0] f0, f1, noise;
  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;

  mux_fault_locator #(.WIDTH(W), .SETTLE(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mux_s      (mux_s),
    .mux_i0     (mux_i0),
    .mux_i1     (mux_i1),
    .obs_wires  (obs_wires),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .suspect    (suspect)
  );

  always #5 clk = ~clk;

  // Fault-free netlist of one mux slice.
  function automatic logic [8:0] mut_wires(input logic i0, input logic i1, input logic s);
    logic nsel, a0, a1, y;
    nsel = ~s;
    a0   = i0 & nsel;
    a1   = i1 & s;
    y    = a0 | a1;
    return {y, a0, a1, nsel, s, s, s, i1, i0};
  endfunction

  // Mux under test: f0 forces a wire low (wins), f1 forces high, noise flips.
  always_comb begin
    obs_wires = '0;
    for (int b = 0; b < W; b++) begin
      obs_wires[9*b +: 9] = ((mut_wires(mux_i0[b], mux_i1[b], mux_s) | f1[9*b +: 9])
                             & ~f0[9*b +: 9]) ^ noise[9*b +: 9];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: walk the 8 vectors, work out what each slice would show
  // under the fault masks, and narrow the suspect mask from the highest
  // mismatching wire.
  task automatic predict(input logic [NW-1:0] ff0, input logic [NW-1:0] ff1,
                         output logic [NW-1:0] sus, output int fc);
    int dep[9];
    int g[9];
    dep = '{'h100, 'h080, 'h040, 'h060, 'h050, 'h058, 'h0E4, 'h15A, 'h1FF};
    sus = '1;
    fc  = 0;
    for (int v = 0; v < 8; v++) begin
      int i0, i1, s, y, bad;
      i0  = (v >> 2) & 1;
      i1  = (v >> 1) & 1;
      s   = v & 1;
      y   = s ? i1 : i0;
      g   = '{i0, i1, s, s, s, 1 - s, i1 * s, i0 * (1 - s), y};
      bad = 0;
      for (int b = 0; b < int'(W); b++) begin
        int kst;
        kst = -1;
        for (int k = 8; k >= 0; k--) begin
          int o;
          o = ff0[9*b + k] ? 0 : (ff1[9*b + k] ? 1 : g[k]);
          if (kst < 0 && o != g[k]) kst = k;
        end
        if (kst >= 0) begin
          bad = 1;
          for (int k = 0; k < 9; k++)
            if (((dep[kst] >> k) & 1) == 0) sus[9*b + k] = 1'b0;
        end
      end
      if (bad != 0 && fc < 8) fc++;
    end
  endtask

  function automatic logic [NW-1:0] sparse();
    logic [NW-1:0] r;
    for (int i = 0; i < int'(NW); i++) r[i] = ($urandom_range(0, 15) == 0);
    return r;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},  64'(busy), 64'(0));
    chk({tag, "_done"},  64'(done), 64'(0));
    chk({tag, "_pass"},  64'(pass), 64'(0));
    chk({tag, "_fc"},    64'(fail_count), 64'(0));
    chk({tag, "_susp"},  64'(suspect), 64'({NW{1'b1}}));
    chk({tag, "_mux"},   64'({mux_s, mux_i0, mux_i1}), 64'(0));
  endtask

  // One full run. Cycle 0 is the cycle start is high; cycle n is observed
  // at the n-th following negedge. start_at re-pulses start in that cycle.
  task automatic run(input string tag, input logic [NW-1:0] ff0, input logic [NW-1:0] ff1,
                     input int start_at, input bit glitch);
    logic [NW-1:0] esus;
    int            efc;
    predict(ff0, ff1, esus, efc);
    @(negedge clk);
    f0    = ff0;
    f1    = ff1;
    noise = '0;
    start = 1'b1;
    for (int n = 1; n <= int'(RUN) + 1; n++) begin
      int v, ph;
      @(negedge clk);
      start = (n == start_at);
      v  = (n - 1) / int'(VC);
      ph = (n - 1) % int'(VC);
      noise = (glitch && n <= int'(RUN) && ph != int'(VC) - 1) ? NW'({$urandom(), $urandom()}) : '0;
      if (n == 1) begin
        chk({tag, "_init_done"}, 64'(done), 64'(0));
        chk({tag, "_init_fc"},   64'(fail_count), 64'(0));
        chk({tag, "_init_susp"}, 64'(suspect), 64'({NW{1'b1}}));
      end
      if (n <= int'(RUN)) begin
        chk({tag, "_busy"}, 64'(busy), 64'(1));
        chk({tag, "_s"},    64'(mux_s), 64'(v & 1));
        chk({tag, "_i0"},   64'(mux_i0), ((v >> 2) & 1) != 0 ? 64'({W{1'b1}}) : 64'(0));
        chk({tag, "_i1"},   64'(mux_i1), ((v >> 1) & 1) != 0 ? 64'({W{1'b1}}) : 64'(0));
      end
      if (n == int'(RUN)) chk({tag, "_done_early"}, 64'(done), 64'(0));
    end
    noise = '0;
    chk({tag, "_done"},     64'(done), 64'(1));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    chk({tag, "_pass"},     64'(pass), 64'(efc == 0));
    chk({tag, "_fc"},       64'(fail_count), 64'(efc));
    chk({tag, "_susp"},     64'(suspect), 64'(esus));
    chk({tag, "_mux_end"},  64'({mux_s, mux_i0, mux_i1}), 64'(0));
  endtask

  initial begin
    logic [NW-1:0] r0;
    rst   = 1'b1;
    start = 1'b0;
    f0    = '0;
    f1    = '0;
    noise = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");

    // start coincident with rst: reset wins, nothing starts.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    check_reset("rst_start");
    @(negedge clk);
    chk("rst_start_idle", 64'(busy), 64'(0));

    run("clean",  '0, '0, 0, 1'b0);
    run("s0w7lo", NW'(1) << 7, '0, 0, 1'b0);
    run("s2w6hi", '0, NW'(1) << (18 + 6), 0, 1'b0);
    run("s1w8lo", NW'(1) << (9 + 8), '0, 0, 1'b0);

    // start while busy (cycle 22 is WAIT of vector 5) is ignored; then
    // a start from DONE reinitialises the results.
    run("busy_start", NW'(1) << 7, '0, 22, 1'b1);
    run("from_done",  '0, NW'(1) << (27 + 3), 0, 1'b1);

    for (int t = 0; t < 12; t++) begin
      r0 = sparse();
      run($sformatf("rand%0d", t), r0, sparse() & ~r0, 0, 1'b1);
    end

    // rst in WAIT of vector 3 discards the partial run.
    @(negedge clk);
    f0    = '0;
    f1    = NW'(1) << (18 + 6);
    start = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midrun_fc", 64'(fail_count), 64'(3));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midrun_rst");
    @(negedge clk);
    chk("midrun_idle", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
